// File: rtl/sprite_capture_writer.sv
// Captures a WIDTH x HEIGHT window of a live pixel stream into one bank of the sprite BRAM as RGB332 keys.
// Optional build macro SPRITE_CAPTURE_CHROMA_KEY_EN: magenta-ish pixels become transparent key 0x00, real black becomes 0x01.
module sprite_capture_writer #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT * 2)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              capture_start_in,
  input  logic              bank_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              data_valid_in,
  input  logic [23:0]       pixel_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              partial_out,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out
);

  localparam int PIX_TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W     = $clog2(PIX_TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              bank_q;
  logic [10:0]       x_q;
  logic [9:0]        y_q;
  logic [CNT_W-1:0]  count_q;

  logic              frame_start;
  logic              in_window;
  logic              last_pixel;
  logic              accept;
  logic              start_ok;
  logic              finish_frame;
  logic [11:0]       x_end;
  logic [10:0]       y_end;
  logic [ADDR_W-1:0] addr_calc;
  logic [7:0]        rgb332;
  logic [7:0]        key;

  assign frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);

  // Window end is one bit wider than the origin so a window near the screen edge never wraps.
  assign x_end = {1'b0, x_q} + 12'(WIDTH);
  assign y_end = {1'b0, y_q} + 11'(HEIGHT);

  assign in_window = (hcount_in >= x_q) && ({1'b0, hcount_in} < x_end) &&
                     (vcount_in >= y_q) && ({1'b0, vcount_in} < y_end);

  assign last_pixel = (count_q == CNT_W'(PIX_TOTAL - 1));

  assign addr_calc = (bank_q ? ADDR_W'(PIX_TOTAL) : '0)
                   + ADDR_W'(32'(vcount_in - y_q) * WIDTH)
                   + ADDR_W'(hcount_in - x_q);

  assign rgb332 = {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]};

`ifdef SPRITE_CAPTURE_CHROMA_KEY_EN
  always_comb begin
    key = rgb332;
    if (pixel_in[23:16] >= 8'hF0 && pixel_in[15:8] <= 8'h0F && pixel_in[7:0] >= 8'hF0) begin
      key = 8'h00;
    end else if (rgb332 == 8'h00) begin
      key = 8'h01;
    end
  end
`else
  logic unused_pixel_bits;
  assign unused_pixel_bits = ^{pixel_in[20:16], pixel_in[12:8], pixel_in[5:0]};
  assign key = rgb332;
`endif

  // NOTE: every signal driven here gets its default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    start_ok     = 1'b0;
    finish_frame = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (capture_start_in) begin
          start_ok = 1'b1;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        // The frame-origin pixel that arms the capture is itself a window candidate.
        if (frame_start) begin
          accept  = in_window;
          state_d = (in_window && last_pixel) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (frame_start) begin
          finish_frame = 1'b1;
          state_d      = S_DONE;
        end else if (data_valid_in && in_window) begin
          accept = 1'b1;
          if (last_pixel) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      bank_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      count_q     <= '0;
      partial_out <= 1'b0;
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      wr_en_out <= accept;
      if (start_ok) begin
        bank_q      <= bank_in;
        x_q         <= x_in;
        y_q         <= y_in;
        count_q     <= '0;
        partial_out <= 1'b0;
      end
      if (accept) begin
        wr_addr_out <= addr_calc;
        wr_data_out <= key;
        count_q     <= count_q + CNT_W'(1);
      end
      // A new frame before the window filled means the window was clipped.
      if (finish_frame) partial_out <= 1'b1;
    end
  end

  assign busy_out = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done_out = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_capture_writer.sv
// Randomized self-checking bench for sprite_capture_writer against a frame-level write-list model.
module tb_sprite_capture_writer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT * 2);
  localparam int TOTAL  = WIDTH * HEIGHT;

`ifdef SPRITE_CAPTURE_CHROMA_KEY_EN
  localparam logic [7:0] K_MAGENTA = 8'h00;
  localparam logic [7:0] K_DARK    = 8'h01;
`else
  localparam logic [7:0] K_MAGENTA = 8'hE3;
  localparam logic [7:0] K_DARK    = 8'h00;
`endif

  logic              pixel_clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              capture_start_in = 1'b0;
  logic              bank_in = 1'b0;
  logic [10:0]       x_in = '0;
  logic [9:0]        y_in = '0;
  logic [10:0]       hcount_in = '0;
  logic [9:0]        vcount_in = '0;
  logic              data_valid_in = 1'b0;
  logic [23:0]       pixel_in = '0;
  logic              busy_out, done_out, partial_out, wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [7:0]        wr_data_out;

  always #5 pixel_clk_in = ~pixel_clk_in;

  sprite_capture_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .pixel_clk_in     (pixel_clk_in),
    .rst_in           (rst_in),
    .capture_start_in (capture_start_in),
    .bank_in          (bank_in),
    .x_in             (x_in),
    .y_in             (y_in),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .data_valid_in    (data_valid_in),
    .pixel_in         (pixel_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .partial_out      (partial_out),
    .wr_en_out        (wr_en_out),
    .wr_addr_out      (wr_addr_out),
    .wr_data_out      (wr_data_out)
  );

  typedef struct {int h; int v; bit valid; logic [23:0] pix;} beat_t;
  typedef struct {int addr; int data; bit done;} wr_t;

  beat_t frm[$];
  wr_t   exp_wr[$];
  wr_t   act_wr[$];
  int    exp_lone_done;
  bit    exp_any_done;
  bit    exp_partial;
  int    act_lone_done;
  int    act_done_cnt;
  logic  act_partial;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge pixel_clk_in) begin
    if (wr_en_out === 1'b1)
      act_wr.push_back('{int'(wr_addr_out), int'(wr_data_out), done_out === 1'b1});
    else if (done_out === 1'b1)
      act_lone_done++;
    if (done_out === 1'b1) begin
      act_done_cnt++;
      act_partial = partial_out;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int encode(input logic [23:0] p);
    logic [7:0] k;
    k = {p[23:21], p[15:13], p[7:6]};
`ifdef SPRITE_CAPTURE_CHROMA_KEY_EN
    if (p[23:16] >= 8'hF0 && p[15:8] <= 8'h0F && p[7:0] >= 8'hF0) k = 8'h00;
    else if (k == 8'h00) k = 8'h01;
`endif
    return int'(k);
  endfunction

  // Expected writes for the queued stream: raster-order window pixels after the first frame origin,
  // ending at the TOTAL-th write or at the next frame origin.
  task automatic model(input int bank, input int x, input int y);
    int cnt;
    bit armed;
    wr_t w;
    cnt = 0;
    armed = 1'b0;
    exp_wr.delete();
    exp_lone_done = 0;
    exp_any_done = 1'b0;
    exp_partial = 1'b0;
    foreach (frm[i]) begin
      if (!frm[i].valid) continue;
      if (frm[i].h == 0 && frm[i].v == 0) begin
        if (armed) begin
          exp_lone_done = 1;
          exp_any_done = 1'b1;
          exp_partial = 1'b1;
          break;
        end
        armed = 1'b1;
      end
      if (!armed) continue;
      if (frm[i].h >= x && frm[i].h < x + WIDTH && frm[i].v >= y && frm[i].v < y + HEIGHT) begin
        cnt++;
        w.addr = (bank * TOTAL + (frm[i].h - x) + (frm[i].v - y) * WIDTH) % (1 << ADDR_W);
        w.data = encode(frm[i].pix);
        w.done = (cnt == TOTAL);
        exp_wr.push_back(w);
        if (cnt == TOTAL) begin
          exp_any_done = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk_in);
    #1;
  endtask

  task automatic clear_mon();
    act_wr.delete();
    act_lone_done = 0;
    act_done_cnt = 0;
    act_partial = 1'b0;
  endtask

  task automatic start(input bit b, input int x, input int y);
    capture_start_in = 1'b1;
    bank_in = b;
    x_in = 11'(x);
    y_in = 10'(y);
    tick();
    capture_start_in = 1'b0;
  endtask

  task automatic gen_frame(input int fw, input int fh, input bit use_fixed, input logic [23:0] fixed_pix,
                           input int invalid_pct, input bit add_next);
    frm.delete();
    for (int v = 0; v < fh; v++) begin
      for (int h = 0; h < fw; h++) begin
        while ($urandom_range(99) < invalid_pct)
          frm.push_back('{int'($urandom_range(fw - 1)), int'($urandom_range(fh - 1)), 1'b0, 24'($urandom)});
        frm.push_back('{h, v, 1'b1, use_fixed ? fixed_pix : 24'($urandom)});
      end
    end
    if (add_next) frm.push_back('{0, 0, 1'b1, 24'($urandom)});
  endtask

  task automatic play(input int pulse_idx, input int pulse_x, input int idle_after);
    foreach (frm[i]) begin
      hcount_in = 11'(frm[i].h);
      vcount_in = 10'(frm[i].v);
      data_valid_in = frm[i].valid;
      pixel_in = frm[i].pix;
      if (i == pulse_idx) begin
        capture_start_in = 1'b1;
        x_in = 11'(pulse_x);
        y_in = '0;
        bank_in = ~bank_in;
      end
      tick();
      capture_start_in = 1'b0;
    end
    data_valid_in = 1'b0;
    repeat (idle_after) tick();
  endtask

  task automatic compare(input string tag);
    check({tag, "/nwr"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++) begin
      check($sformatf("%s/addr%0d", tag, i), act_wr[i].addr, exp_wr[i].addr);
      check($sformatf("%s/data%0d", tag, i), act_wr[i].data, exp_wr[i].data);
      check($sformatf("%s/done%0d", tag, i), act_wr[i].done, exp_wr[i].done);
    end
    check({tag, "/lone_done"}, act_lone_done, exp_lone_done);
    check({tag, "/done_cnt"}, act_done_cnt, exp_any_done);
    if (exp_any_done) check({tag, "/partial"}, act_partial, exp_partial);
    check({tag, "/busy_end"}, busy_out, 1'b0);
  endtask

  task automatic run_capture(input string tag, input bit bank, input int x, input int y,
                             input int fw, input int fh, input bit use_fixed, input logic [23:0] fixed_pix,
                             input int invalid_pct, input bit add_next, input int pulse_idx, input bit chroma_pat);
    clear_mon();
    gen_frame(fw, fh, use_fixed, fixed_pix, invalid_pct, add_next);
    if (chroma_pat) begin
      foreach (frm[i]) begin
        if (frm[i].valid && frm[i].v == y) frm[i].pix = 24'hFF00FF;
        if (frm[i].valid && frm[i].v == y + 1) frm[i].pix = 24'h101010;
      end
    end
    start(bank, x, y);
    check({tag, "/busy_armed"}, busy_out, 1'b1);
    model(bank, x, y);
    play(pulse_idx, 20, 3);
    compare(tag);
  endtask

  initial begin
    rst_in = 1'b0;
    repeat (2) tick();
    check("rst/wr_en", wr_en_out, 1'b0);
    check("rst/busy", busy_out, 1'b0);
    check("rst/done", done_out, 1'b0);
    check("rst/partial", partial_out, 1'b0);
    check("rst/addr", wr_addr_out, 0);
    check("rst/data", wr_data_out, 0);
    rst_in = 1'b1;
    tick();

    run_capture("bank0", 1'b0, 10, 5, 32, 8, 1'b1, 24'hFF8040, 0, 1'b0, -1, 1'b0);
    for (int i = 0; i < act_wr.size(); i++)
      check($sformatf("bank0/raster%0d", i), act_wr[i].addr, i);

    run_capture("bank1", 1'b1, 10, 5, 32, 8, 1'b0, 24'h0, 20, 1'b0, -1, 1'b0);
    for (int i = 0; i < act_wr.size(); i++)
      check($sformatf("bank1/raster%0d", i), act_wr[i].addr, TOTAL + i);

    clear_mon();
    gen_frame(32, 8, 1'b0, 24'h0, 10, 1'b1);
    play(-1, 0, 3);
    check("nostart/nwr", act_wr.size(), 0);
    check("nostart/done_cnt", act_done_cnt, 0);
    check("nostart/busy", busy_out, 1'b0);

    run_capture("clip", 1'b0, 1278, 5, 1280, 8, 1'b0, 24'h0, 0, 1'b1, -1, 1'b0);
    check("clip/nwr_const", act_wr.size(), 4);
    check("clip/partial_const", act_partial, 1'b1);
    check("clip/lone_done_const", act_lone_done, 1);

    clear_mon();
    start(1'b0, 10, 5);
    frm.delete();
    frm.push_back('{0, 0, 1'b1, 24'h123456});
    frm.push_back('{10, 5, 1'b1, 24'hABCDEF});
    frm.push_back('{11, 5, 1'b1, 24'h13579B});
    frm.push_back('{12, 5, 1'b1, 24'h2468AC});
    play(-1, 0, 0);
    rst_in = 1'b0;
    tick();
    check("rstmid/wr_en", wr_en_out, 1'b0);
    check("rstmid/busy", busy_out, 1'b0);
    check("rstmid/done", done_out, 1'b0);
    rst_in = 1'b1;
    repeat (3) tick();
    check("rstmid/nwr", act_wr.size(), 3);
    for (int i = 0; i < act_wr.size(); i++)
      check($sformatf("rstmid/addr%0d", i), act_wr[i].addr, i);
    check("rstmid/done_cnt", act_done_cnt, 0);
    check("rstmid/busy_after", busy_out, 1'b0);

    run_capture("restart", 1'b0, 10, 5, 32, 8, 1'b0, 24'h0, 15, 1'b0, -1, 1'b0);
    for (int i = 0; i < act_wr.size(); i++)
      check($sformatf("restart/raster%0d", i), act_wr[i].addr, i);

    run_capture("busystart", 1'b0, 10, 5, 32, 8, 1'b0, 24'h0, 0, 1'b0, 67, 1'b0);

    run_capture("chroma", 1'b0, 0, 0, 32, 8, 1'b0, 24'h0, 10, 1'b0, -1, 1'b1);
    if (act_wr.size() > 4) begin
      check("chroma/magenta", act_wr[0].data, K_MAGENTA);
      check("chroma/dark", act_wr[4].data, K_DARK);
    end else begin
      check("chroma/nwr_short", act_wr.size(), TOTAL);
    end

    for (int n = 0; n < 8; n++) begin
      run_capture($sformatf("rand%0d", n), 1'($urandom_range(1)), int'($urandom_range(31)),
                  int'($urandom_range(7)), 32, 8, 1'b0, 24'h0, 30, 1'b1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
